pat_his_tab: RTL

- Second-level pattern history table (PHT) of the two-level local branch predictor.
- Sits directly downstream of the branch history table. The 10-bit local history read from the BHT indexes an array of 2-bit saturating counters, and the counter MSB is the taken/not-taken prediction.
- Resolved branches update the indexed counter through a one-entry write pipeline with forwarding.
- A mispredict statistics counter is included.

---
 rtl/pat_his_tab_if.sv | 30 +++
 rtl/pat_his_tab.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pat_his_tab_if.sv
// Lookup/update/status bundle between the branch front end and the PHT.
// Latency: none, this is a wiring bundle only.
// Backpressure: none; requests are always accepted and results are valid-only.
interface pat_his_tab_if #(
    parameter int HIS_W = 10,
    parameter int CNT_W = 2,
    parameter int MIS_W = 16
);
    logic             ready;
    logic             pre_en;
    logic [HIS_W-1:0] pre_his;
    logic             pre_vld;
    logic [CNT_W-1:0] pre_cnt;
    logic             pre_taken;
    logic             up_en;
    logic [HIS_W-1:0] up_his;
    logic             up_taken;
    logic             up_pred;
    logic [MIS_W-1:0] mis_cnt;

    modport master (
        output pre_en, pre_his, up_en, up_his, up_taken, up_pred,
        input  ready, pre_vld, pre_cnt, pre_taken, mis_cnt
    );

    modport slave (
        input  pre_en, pre_his, up_en, up_his, up_taken, up_pred,
        output ready, pre_vld, pre_cnt, pre_taken, mis_cnt
    );
endinterface

// File: rtl/pat_his_tab.sv
// Pattern history table: 2-bit saturating counters indexed by local history.
// Latency: lookup result one cycle after pre_en; update commits one cycle after capture.
// Backpressure: none; lookups and updates are accepted every cycle (updates ignored until ready).
module pat_his_tab #(
    parameter int                HIS_W    = 10,
    parameter int                DEPTH    = 1024,
    parameter int                CNT_W    = 2,
    parameter logic [CNT_W-1:0]  INIT_CNT = CNT_W'(1),
    parameter int                MIS_W    = 16
) (
    input  logic         clk,
    input  logic         reset,
    pat_his_tab_if.slave bus
);

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [HIS_W-1:0] LAST_IDX = HIS_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [MIS_W-1:0] MIS_MAX  = '1;

    // Counter array has no reset; the INIT walk rewrites every entry.
    logic [CNT_W-1:0] r_tab [DEPTH];

    state_t           r_state;
    state_t           w_state_nxt;
    logic [HIS_W-1:0] r_init_idx;
    logic             w_init_we;
    logic             w_run;

    logic             r_pend_vld;
    logic [HIS_W-1:0] r_pend_idx;
    logic [CNT_W-1:0] r_pend_cnt;

    logic             r_pre_vld;
    logic [CNT_W-1:0] r_pre_cnt;
    logic [MIS_W-1:0] r_mis_cnt;

    logic [CNT_W-1:0] w_lkp_cnt;
    logic [CNT_W-1:0] w_up_src;
    logic [CNT_W-1:0] w_up_new;
    logic             w_up_acc;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_INIT;
        else        r_state <= w_state_nxt;
    end

    // FSM next state: leave INIT on the edge that writes the last entry.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && r_init_idx == LAST_IDX) w_state_nxt = ST_RUN;
    end

    // FSM outputs.
    always_comb begin
        w_init_we = (r_state == ST_INIT);
        w_run     = (r_state == ST_RUN);
    end

    // Initialisation index walks the whole table once after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         r_init_idx <= '0;
        else if (w_init_we) r_init_idx <= r_init_idx + HIS_W'(1);
    end

    // Lookup value: INIT answers the init value, otherwise forward the pending write.
    always_comb begin
        w_lkp_cnt = r_tab[bus.pre_his];
        if (!w_run)
            w_lkp_cnt = INIT_CNT;
        else if (r_pend_vld && r_pend_idx == bus.pre_his)
            w_lkp_cnt = r_pend_cnt;
    end

    // Update source (with forwarding) and saturating next count.
    always_comb begin
        w_up_acc = bus.up_en && w_run;
        w_up_src = r_tab[bus.up_his];
        if (r_pend_vld && r_pend_idx == bus.up_his) w_up_src = r_pend_cnt;
        if (bus.up_taken) w_up_new = (w_up_src == CNT_MAX) ? w_up_src : w_up_src + CNT_W'(1);
        else              w_up_new = (w_up_src == '0)      ? w_up_src : w_up_src - CNT_W'(1);
    end

    // One-entry pending write register; an in-flight update is dropped on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend_vld <= 1'b0;
            r_pend_idx <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_pend_vld <= w_up_acc;
            if (w_up_acc) begin
                r_pend_idx <= bus.up_his;
                r_pend_cnt <= w_up_new;
            end
        end
    end

    // Single table write port: init walk, else commit of the pending write.
    always_ff @(posedge clk) begin
        if (w_init_we)       r_tab[r_init_idx] <= INIT_CNT;
        else if (r_pend_vld) r_tab[r_pend_idx] <= r_pend_cnt;
    end

    // Lookup result register; count holds while no request is presented.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre_vld <= 1'b0;
            r_pre_cnt <= '0;
        end else begin
            r_pre_vld <= bus.pre_en;
            if (bus.pre_en) r_pre_cnt <= w_lkp_cnt;
        end
    end

    // Saturating mispredict counter, only counts accepted updates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_mis_cnt <= '0;
        else if (w_up_acc && (bus.up_pred != bus.up_taken) && r_mis_cnt != MIS_MAX)
            r_mis_cnt <= r_mis_cnt + MIS_W'(1);
    end

    assign bus.ready     = w_run;
    assign bus.pre_vld   = r_pre_vld;
    assign bus.pre_cnt   = r_pre_cnt;
    assign bus.pre_taken = r_pre_cnt[CNT_W-1];
    assign bus.mis_cnt   = r_mis_cnt;

endmodule
